// File: rtl/gpio_collector_if.sv
// Bundle of channel inputs, controls and status outputs shared by the
// collector and whatever drives it (processor glue or testbench).
interface gpio_collector_if;
    logic        dout_0;
    logic        dout_1;
    logic        dout_2;
    logic        dout_3;
    logic        dout_en_0;
    logic        dout_en_1;
    logic        dout_en_2;
    logic        dout_en_3;
    logic [3:0]  clr;
    logic        irq_en;
    logic [31:0] gpio_out;
    logic        irq;

    modport master (
        output dout_0, dout_1, dout_2, dout_3,
        output dout_en_0, dout_en_1, dout_en_2, dout_en_3,
        output clr, irq_en,
        input  gpio_out, irq
    );

    modport slave (
        input  dout_0, dout_1, dout_2, dout_3,
        input  dout_en_0, dout_en_1, dout_en_2, dout_en_3,
        input  clr, irq_en,
        output gpio_out, irq
    );
endinterface

// File: rtl/gpio_collector.sv
// Four-channel GPIO event collector: synchronizes channel returns, tracks
// level, sticky rise/fall flags and a saturating rise count per channel.
module gpio_collector (
    input  logic           clk,
    input  logic           rst_n,
    gpio_collector_if.slave bus
);

    logic [3:0] dout_vec;
    logic [3:0] en_vec;
    logic [3:0] s1_reg;
    logic [3:0] s2_reg;
    logic [3:0] prev_reg;
    logic [1:0] arm_cnt_reg;
    logic       armed;
    logic [3:0] flag_vec;
    logic [3:0][7:0] byte_vec;
    logic       irq_reg;

    assign dout_vec = {bus.dout_3, bus.dout_2, bus.dout_1, bus.dout_0};
    assign en_vec   = {bus.dout_en_3, bus.dout_en_2, bus.dout_en_1, bus.dout_en_0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= 4'b0;
            s2_reg   <= 4'b0;
            prev_reg <= 4'b0;
        end else begin
            s1_reg   <= dout_vec;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    // Edge detection stays disarmed until prev has loaded a real synchronized
    // sample, so an input already high at reset release is not seen as a rise.
    assign armed = (arm_cnt_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_reg <= 2'd0;
        end else if (!armed) begin
            arm_cnt_reg <= arm_cnt_reg + 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic [7:0] ch_reg;
            logic [7:0] ch_next;
            logic       rise;
            logic       fall;

            assign rise = armed & en_vec[gi] &  s2_reg[gi] & ~prev_reg[gi];
            assign fall = armed & en_vec[gi] & ~s2_reg[gi] &  prev_reg[gi];

            // Clear is applied first so a coincident edge survives the clear.
            always_comb begin
                ch_next = ch_reg;
                if (bus.clr[gi]) begin
                    ch_next[3:1] = 3'b000;
                    ch_next[7:4] = 4'h0;
                end
                if (rise) begin
                    ch_next[1] = 1'b1;
                    if (ch_next[7:4] == 4'hF) begin
                        ch_next[3] = 1'b1;
                    end else begin
                        ch_next[7:4] = ch_next[7:4] + 4'h1;
                    end
                end
                if (fall) begin
                    ch_next[2] = 1'b1;
                end
                ch_next[0] = en_vec[gi] & s2_reg[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ch_reg <= 8'h00;
                end else begin
                    ch_reg <= ch_next;
                end
            end

            assign byte_vec[gi] = ch_reg;
            assign flag_vec[gi] = ch_reg[1] | ch_reg[2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= bus.irq_en & (|flag_vec);
        end
    end

    assign bus.gpio_out = byte_vec;
    assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_gpio_collector.sv
// Directed self-checking bench for gpio_collector with hand-computed expectations.
module tb_gpio_collector;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    gpio_collector_if bus_if ();

    gpio_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("check %s ok: %08h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_all_dout(input logic v);
        bus_if.dout_0 = v;
        bus_if.dout_1 = v;
        bus_if.dout_2 = v;
        bus_if.dout_3 = v;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        set_all_dout(1'b0);
        bus_if.dout_en_0 = 1'b0;
        bus_if.dout_en_1 = 1'b0;
        bus_if.dout_en_2 = 1'b0;
        bus_if.dout_en_3 = 1'b0;
        bus_if.clr    = 4'h0;
        bus_if.irq_en = 1'b0;

        tick(3);
        check("reset_gpio", bus_if.gpio_out, 32'h0);
        check("reset_irq", {31'b0, bus_if.irq}, 32'h0);

        rst_n = 1'b1;
        bus_if.dout_en_0 = 1'b1;
        bus_if.dout_en_1 = 1'b1;
        bus_if.dout_en_2 = 1'b1;
        bus_if.dout_en_3 = 1'b1;
        bus_if.irq_en = 1'b1;
        tick(5);
        check("idle_gpio", bus_if.gpio_out, 32'h0);

        // single rise on channel 0, latency 3 to gpio_out, 4 to irq
        bus_if.dout_0 = 1'b1;
        tick(2);
        check("ch0_lat2", bus_if.gpio_out, 32'h0);
        tick(1);
        check("ch0_lat3", bus_if.gpio_out, 32'h00000013);
        check("ch0_irq_lat3", {31'b0, bus_if.irq}, 32'h0);
        tick(1);
        check("ch0_irq_lat4", {31'b0, bus_if.irq}, 32'h1);
        bus_if.clr = 4'b0001;
        tick(1);
        bus_if.clr = 4'b0000;
        check("ch0_clr", bus_if.gpio_out, 32'h00000001);
        tick(1);
        check("ch0_irq_drop", {31'b0, bus_if.irq}, 32'h0);
        bus_if.dout_0 = 1'b0;
        tick(3);
        check("ch0_fall", bus_if.gpio_out, 32'h00000004);
        bus_if.clr = 4'b0001;
        tick(1);
        bus_if.clr = 4'b0000;
        check("ch0_clr2", bus_if.gpio_out, 32'h0);

        // saturation on channel 2
        for (int i = 0; i < 15; i++) begin
            bus_if.dout_2 = 1'b0; tick(2);
            bus_if.dout_2 = 1'b1; tick(2);
        end
        tick(3);
        check("ch2_cnt15", {24'b0, bus_if.gpio_out[23:16]}, 32'hF7);
        for (int i = 0; i < 2; i++) begin
            bus_if.dout_2 = 1'b0; tick(2);
            bus_if.dout_2 = 1'b1; tick(2);
        end
        tick(3);
        check("ch2_sat", {24'b0, bus_if.gpio_out[23:16]}, 32'hFF);
        bus_if.clr = 4'b0100;
        tick(1);
        bus_if.clr = 4'b0000;
        check("ch2_clr", {24'b0, bus_if.gpio_out[23:16]}, 32'h01);

        // clear coincident with rise on channel 1
        bus_if.dout_1 = 1'b1; tick(2);
        bus_if.dout_1 = 1'b0; tick(3);
        check("ch1_pre", {24'b0, bus_if.gpio_out[15:8]}, 32'h16);
        bus_if.dout_1 = 1'b1;
        tick(2);
        bus_if.clr = 4'b0010;
        tick(1);
        bus_if.clr = 4'b0000;
        check("ch1_clr_rise", {24'b0, bus_if.gpio_out[15:8]}, 32'h13);

        // disabled channel 3 ignores toggles, re-enable gives no edge
        bus_if.dout_en_3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.dout_3 = ~bus_if.dout_3;
            tick(2);
        end
        tick(3);
        check("ch3_disabled", {24'b0, bus_if.gpio_out[31:24]}, 32'h00);
        bus_if.dout_en_3 = 1'b1;
        tick(1);
        check("ch3_reen", {24'b0, bus_if.gpio_out[31:24]}, 32'h01);
        tick(3);
        check("ch3_noedge", {24'b0, bus_if.gpio_out[31:24]}, 32'h01);

        // mid-operation reset with inputs held high
        bus_if.dout_0 = 1'b1; tick(3);
        check("ch0_cnt1", {24'b0, bus_if.gpio_out[7:0]}, 32'h13);
        bus_if.dout_0 = 1'b0; tick(2);
        bus_if.dout_0 = 1'b1; tick(3);
        check("ch0_cnt2", {24'b0, bus_if.gpio_out[7:0]}, 32'h27);
        rst_n = 1'b0;
        #1;
        check("rst_async_gpio", bus_if.gpio_out, 32'h0);
        check("rst_async_irq", {31'b0, bus_if.irq}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rst_release", bus_if.gpio_out, 32'h01010101);
        check("rst_release_irq", {31'b0, bus_if.irq}, 32'h0);
        tick(3);
        check("rst_settled", bus_if.gpio_out, 32'h01010101);
        check("rst_settled_irq", {31'b0, bus_if.irq}, 32'h0);

        // simultaneous rises on all channels with irq masked
        bus_if.irq_en = 1'b0;
        set_all_dout(1'b0);
        tick(3);
        bus_if.clr = 4'hF;
        tick(1);
        bus_if.clr = 4'h0;
        check("all_clr", bus_if.gpio_out, 32'h0);
        tick(1);
        set_all_dout(1'b1);
        tick(2);
        check("all_lat2", bus_if.gpio_out, 32'h0);
        tick(1);
        check("all_rise", bus_if.gpio_out, 32'h13131313);
        tick(1);
        check("all_irq_masked", {31'b0, bus_if.irq}, 32'h0);
        bus_if.irq_en = 1'b1;
        tick(1);
        check("all_irq_unmask", {31'b0, bus_if.irq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
